// File: rtl/spu_clk_en_gen.sv
// spu_clk_en_gen: SPU clock-enable generator.
// Waits for a synchronized PLL lock, holds the core in reset for SETTLE_CYCLES,
// then produces voice-slot and sample-period strobes plus slot counters.
// Optional macro SPU_LOCK_LOSS_CNT_EN adds an 8-bit saturating lock-loss counter.
module spu_clk_en_gen #(
  parameter int SETTLE_CYCLES = 4096,
  parameter int SLOT_CYCLES   = 32,
  parameter int VOICES        = 24
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       pause,
  output logic       core_reset,
  output logic       voice_ce,
  output logic       sample_ce,
  output logic [4:0] voice_idx,
  output logic [5:0] slot_phase
`ifdef SPU_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam logic [15:0] SETTLE_MAX = 16'(SETTLE_CYCLES - 1);
  localparam logic [5:0]  PHASE_MAX  = 6'(SLOT_CYCLES - 1);
  localparam logic [4:0]  IDX_MAX    = 5'(VOICES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        lock_m;
  logic        lock_s;
  logic [15:0] settle_cnt;
  logic [15:0] settle_cnt_next;
  logic [5:0]  phase_next;
  logic [4:0]  idx_next;
  logic        voice_ce_next;
  logic        sample_ce_next;

  // Two-flop synchronizer bringing the raw PLL lock flag into clk_sys.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  // State and settle-counter registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_LOCK;
      settle_cnt <= 16'd0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they can be registered.
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    phase_next      = slot_phase;
    idx_next        = voice_idx;
    voice_ce_next   = 1'b0;
    sample_ce_next  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        settle_cnt_next = 16'd0;
        phase_next      = 6'd0;
        idx_next        = 5'd0;
        if (lock_s) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        phase_next = 6'd0;
        idx_next   = 5'd0;
        if (!lock_s) begin
          state_next      = WAIT_LOCK;
          settle_cnt_next = 16'd0;
        end else if (settle_cnt == SETTLE_MAX) begin
          state_next      = RUN;
          settle_cnt_next = 16'd0;
          voice_ce_next   = 1'b1;
          sample_ce_next  = 1'b1;
        end else begin
          settle_cnt_next = settle_cnt + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          phase_next = 6'd0;
          idx_next   = 5'd0;
        end else if (!pause) begin
          if (slot_phase == PHASE_MAX) begin
            phase_next     = 6'd0;
            idx_next       = (voice_idx == IDX_MAX) ? 5'd0 : voice_idx + 5'd1;
            voice_ce_next  = 1'b1;
            sample_ce_next = (voice_idx == IDX_MAX);
          end else begin
            phase_next = slot_phase + 6'd1;
          end
        end
      end
      default: begin
        state_next      = WAIT_LOCK;
        settle_cnt_next = 16'd0;
        phase_next      = 6'd0;
        idx_next        = 5'd0;
      end
    endcase
  end

  // Registered outputs driven from the precomputed next values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      core_reset <= 1'b1;
      voice_ce   <= 1'b0;
      sample_ce  <= 1'b0;
      voice_idx  <= 5'd0;
      slot_phase <= 6'd0;
    end else begin
      core_reset <= (state_next != RUN);
      voice_ce   <= voice_ce_next;
      sample_ce  <= sample_ce_next;
      voice_idx  <= idx_next;
      slot_phase <= phase_next;
    end
  end

`ifdef SPU_LOCK_LOSS_CNT_EN
  // Saturating count of lock drops that kick the core out of RUN.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_cnt <= 8'd0;
    end else if (state == RUN && state_next == WAIT_LOCK && lock_loss_cnt != 8'hFF) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spu_clk_en_gen.sv
// tb_spu_clk_en_gen: self-checking bench for spu_clk_en_gen.
// A short settle time keeps the repeated lock-drop sequence quick.
module tb_spu_clk_en_gen;

  localparam int SETTLE = 64;
  localparam int SLOT   = 32;
  localparam int NV     = 24;
  localparam int RUN_LATENCY = SETTLE + 3;

  logic       clk_sys;
  logic       reset_n;
  logic       pll_locked;
  logic       pause;
  logic       core_reset;
  logic       voice_ce;
  logic       sample_ce;
  logic [4:0] voice_idx;
  logic [5:0] slot_phase;
`ifdef SPU_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  typedef struct {
    int idx;
    int sample;
    int gap;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests_run  = 0;
  int   fail_count = 0;
  int   cyc        = 0;
  int   last_strobe = 0;
  int   drops      = 0;

  spu_clk_en_gen #(
    .SETTLE_CYCLES(SETTLE),
    .SLOT_CYCLES  (SLOT),
    .VOICES       (NV)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .pause     (pause),
    .core_reset(core_reset),
    .voice_ce  (voice_ce),
    .sample_ce (sample_ce),
    .voice_idx (voice_idx),
    .slot_phase(slot_phase)
`ifdef SPU_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  // Free-running system clock.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rst_v, input logic lock_v, input logic pause_v);
    reset_n    = rst_v;
    pll_locked = lock_v;
    pause      = pause_v;
  endtask

  task automatic push_exp(input int idx, input int sample, input int gap);
    exp_t e;
    e.idx    = idx;
    e.sample = sample;
    e.gap    = gap;
    sb_q.push_back(e);
  endtask

  // Counts cycles until core_reset is released; the count must match exactly.
  task automatic wait_run(input int expected, input string name);
    int  n = 0;
    bit  done = 0;
    while (!done && n < expected + 50) begin
      @(negedge clk_sys);
      n++;
      if (!core_reset) done = 1;
    end
    check_output(name, n, expected);
  endtask

  task automatic wait_idx_phase(input int idx, input int phase, input int budget, input string name);
    int n = 0;
    bit found = 0;
    while (!found && n < budget) begin
      @(negedge clk_sys);
      n++;
      if (voice_idx == 5'(idx) && slot_phase == 6'(phase)) found = 1;
    end
    check_output(name, found, 1);
  endtask

  task automatic wait_queue_empty(input int budget, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check_output(name, sb_q.size(), 0);
  endtask

  // Scoreboard monitor: every voice strobe pops and checks one expected record.
  always @(negedge clk_sys) begin
    cyc++;
    if (sample_ce) check_output("sample_ce implies voice_ce", voice_ce, 1);
    if (voice_ce) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected voice_ce", voice_ce, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_output("strobe voice_idx", voice_idx, mon_e.idx);
        check_output("strobe sample_ce", sample_ce, mon_e.sample);
        check_output("strobe slot_phase", slot_phase, 0);
        if (mon_e.gap != 0) check_output("strobe spacing", cyc - last_strobe, mon_e.gap);
      end
      last_strobe = cyc;
    end
  end

  initial begin
    apply_stimulus(1'b0, 1'b0, 1'b0);

    // Reset values.
    repeat (3) @(negedge clk_sys);
    check_output("reset core_reset", core_reset, 1);
    check_output("reset voice_ce", voice_ce, 0);
    check_output("reset sample_ce", sample_ce, 0);
    check_output("reset voice_idx", voice_idx, 0);
    check_output("reset slot_phase", slot_phase, 0);
`ifdef SPU_LOCK_LOSS_CNT_EN
    check_output("reset lock_loss_cnt", lock_loss_cnt, 0);
`endif

    // Lock held high through reset release: RUN after 2 sync + 1 + SETTLE cycles.
    push_exp(0, 1, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    wait_run(RUN_LATENCY, "first core_reset release");

    // Two full sample periods of steady running.
    for (int k = 1; k <= 2 * NV; k++) push_exp(k % NV, (k % NV == 0) ? 1 : 0, SLOT);
    wait_queue_empty(2 * NV * SLOT + 20, "steady run strobes");

    // Pause for 10 cycles at slot 5 phase 7.
    for (int k = 1; k <= 7; k++) push_exp(k, 0, (k == 6) ? SLOT + 10 : SLOT);
    wait_idx_phase(5, 7, 6 * SLOT + 40, "reach 5/7");
    apply_stimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      check_output("paused voice_idx", voice_idx, 5);
      check_output("paused slot_phase", slot_phase, 7);
      check_output("paused voice_ce", voice_ce, 0);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0);
    @(negedge clk_sys);
    check_output("resume voice_idx", voice_idx, 5);
    check_output("resume slot_phase", slot_phase, 8);
    wait_queue_empty(3 * SLOT + 20, "post-pause strobes");

    // Lock drop in RUN: core_reset rises on the third edge after the drop.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk_sys);
    check_output("drop core_reset still low", core_reset, 0);
    @(negedge clk_sys);
    check_output("drop core_reset", core_reset, 1);
    check_output("drop voice_idx", voice_idx, 0);
    check_output("drop slot_phase", slot_phase, 0);
    check_output("drop voice_ce", voice_ce, 0);
    drops = 1;
`ifdef SPU_LOCK_LOSS_CNT_EN
    check_output("lock_loss_cnt first", lock_loss_cnt, 1);
`endif
    repeat (4) @(negedge clk_sys);

    // Glitch during SETTLE at count 20 forces a full re-settle.
    apply_stimulus(1'b1, 1'b1, 1'b0);
    repeat (3 + 20) @(negedge clk_sys);
    check_output("settle core_reset held", core_reset, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk_sys);
    check_output("glitch core_reset held", core_reset, 1);
    push_exp(0, 1, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    wait_run(RUN_LATENCY, "re-settle after glitch");

    // Repeated lock drops right at RUN entry; counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk_sys);
      check_output("loop core_reset before", core_reset, 0);
      @(negedge clk_sys);
      check_output("loop core_reset after", core_reset, 1);
      drops++;
`ifdef SPU_LOCK_LOSS_CNT_EN
      check_output("loop lock_loss_cnt", lock_loss_cnt, (drops > 255) ? 255 : drops);
`endif
      push_exp(0, 1, 0);
      apply_stimulus(1'b1, 1'b1, 1'b0);
      wait_run(RUN_LATENCY, "loop re-lock");
    end

    // Asynchronous reset mid-sample at voice 12.
    for (int k = 1; k <= 12; k++) push_exp(k, 0, SLOT);
    wait_idx_phase(12, 5, 13 * SLOT, "reach 12/5");
    #2;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    #1;
    check_output("async core_reset", core_reset, 1);
    check_output("async voice_ce", voice_ce, 0);
    check_output("async sample_ce", sample_ce, 0);
    check_output("async voice_idx", voice_idx, 0);
    check_output("async slot_phase", slot_phase, 0);
`ifdef SPU_LOCK_LOSS_CNT_EN
    check_output("async lock_loss_cnt", lock_loss_cnt, 0);
`endif
    repeat (2) @(negedge clk_sys);
    check_output("queue drained before restart", sb_q.size(), 0);

    // Release reset with lock still high: full restart from WAIT_LOCK.
    push_exp(0, 1, 0);
    push_exp(1, 0, SLOT);
    push_exp(2, 0, SLOT);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    wait_run(RUN_LATENCY, "restart after reset");
    wait_queue_empty(3 * SLOT + 20, "restart strobes");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
